// File: rtl/simmem_ram_port_arbiter.sv
// Shares the STRUCT and NEXT_ELEM response-bank RAMs between the READ_DATA and
// WRITE_RESP channels. Each (bank, port) pair is arbitrated round-robin on its own.
// Grants are combinational. Read data returns to the issuer one cycle after grant.
module simmem_ram_port_arbiter #(
  parameter int unsigned AddrWidth = 6,
  parameter int unsigned DataWidth = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [1:0]               req_valid_i,
  output logic [1:0]               req_ready_o,
  input  logic [1:0]               req_bank_i,
  input  logic [1:0]               req_port_i,
  input  logic [2*AddrWidth-1:0]   req_addr_i,
  input  logic [2*DataWidth-1:0]   req_wdata_i,
  output logic [1:0]               rsp_valid_o,
  output logic [2*DataWidth-1:0]   rsp_rdata_o,
  output logic [1:0]               ram_in_req_o,
  output logic [2*AddrWidth-1:0]   ram_in_addr_o,
  output logic [2*DataWidth-1:0]   ram_in_wdata_o,
  output logic [1:0]               ram_out_req_o,
  output logic [2*AddrWidth-1:0]   ram_out_addr_o,
  input  logic [2*DataWidth-1:0]   ram_out_rdata_i
);

  localparam int unsigned NumReq  = 2;
  localparam int unsigned NumBank = 2;
  localparam int unsigned NumPort = 2;

  typedef enum logic {RAM_IN = 1'b0, RAM_OUT = 1'b1} ram_port_e;

  // Indexed [bank][port][requester]; prio bit names the requester that wins a tie.
  logic [NumBank-1:0][NumPort-1:0][NumReq-1:0] arb_gnt;
  logic [NumBank-1:0][NumPort-1:0][NumReq-1:0] gnt;
  logic [NumBank-1:0][NumPort-1:0]             contested;
  logic [NumBank-1:0][NumPort-1:0]             prio_q, prio_d;
  logic [NumReq-1:0]                           rd_gnt, rsp_pend_q;
  logic [NumReq-1:0]                           rd_bank, rsp_bank_q;

  // Per-resource round-robin: sole requester wins, ties go to the priority holder.
  always_comb begin : arbitrate
    logic [NumReq-1:0] want;
    want      = '0;
    arb_gnt   = '0;
    contested = '0;
    for (int b = 0; b < NumBank; b++) begin
      for (int p = 0; p < NumPort; p++) begin
        for (int r = 0; r < NumReq; r++) begin
          want[r] = req_valid_i[r] && (req_bank_i[r] == 1'(b)) && (req_port_i[r] == 1'(p));
        end
        contested[b][p] = &want;
        if (contested[b][p]) begin
          arb_gnt[b][p] = prio_q[b][p] ? 2'b10 : 2'b01;
        end else begin
          arb_gnt[b][p] = want;
        end
      end
    end
  end

  // Same-bank same-address read and write in one cycle: the write wins, the read waits.
  always_comb begin : hazard
    logic [AddrWidth-1:0] wr_addr;
    logic [AddrWidth-1:0] rd_addr;
    gnt     = arb_gnt;
    wr_addr = '0;
    rd_addr = '0;
    for (int b = 0; b < NumBank; b++) begin
      wr_addr = arb_gnt[b][RAM_IN][1]  ? req_addr_i[AddrWidth +: AddrWidth]
                                       : req_addr_i[0 +: AddrWidth];
      rd_addr = arb_gnt[b][RAM_OUT][1] ? req_addr_i[AddrWidth +: AddrWidth]
                                       : req_addr_i[0 +: AddrWidth];
      if ((|arb_gnt[b][RAM_IN]) && (|arb_gnt[b][RAM_OUT]) && (wr_addr == rd_addr)) begin
        gnt[b][RAM_OUT] = '0;
      end
    end
  end

  // Route granted requests to the RAM ports and advance priority on contested grants.
  always_comb begin : route
    req_ready_o    = '0;
    ram_in_req_o   = '0;
    ram_in_addr_o  = '0;
    ram_in_wdata_o = '0;
    ram_out_req_o  = '0;
    ram_out_addr_o = '0;
    rd_gnt         = '0;
    rd_bank        = '0;
    prio_d         = prio_q;
    for (int b = 0; b < NumBank; b++) begin
      for (int p = 0; p < NumPort; p++) begin
        for (int r = 0; r < NumReq; r++) begin
          if (gnt[b][p][r]) begin
            req_ready_o[r] = 1'b1;
            if (1'(p) == RAM_IN) begin
              ram_in_req_o[b]                          = 1'b1;
              ram_in_addr_o[b*AddrWidth +: AddrWidth]  = req_addr_i[r*AddrWidth +: AddrWidth];
              ram_in_wdata_o[b*DataWidth +: DataWidth] = req_wdata_i[r*DataWidth +: DataWidth];
            end else begin
              ram_out_req_o[b]                         = 1'b1;
              ram_out_addr_o[b*AddrWidth +: AddrWidth] = req_addr_i[r*AddrWidth +: AddrWidth];
              rd_gnt[r]                                = 1'b1;
              rd_bank[r]                               = 1'(b);
            end
            if (contested[b][p]) begin
              prio_d[b][p] = ~1'(r);
            end
          end
        end
      end
    end
  end

  // Priority and pending-read state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q     <= '0;
      rsp_pend_q <= '0;
      rsp_bank_q <= '0;
    end else begin
      prio_q     <= prio_d;
      rsp_pend_q <= rd_gnt;
      rsp_bank_q <= rd_bank;
    end
  end

  // Return read data from the bank each requester read last cycle.
  always_comb begin : respond
    rsp_valid_o = rsp_pend_q;
    rsp_rdata_o = '0;
    for (int r = 0; r < NumReq; r++) begin
      if (rsp_pend_q[r]) begin
        rsp_rdata_o[r*DataWidth +: DataWidth] = rsp_bank_q[r] ? ram_out_rdata_i[DataWidth +: DataWidth]
                                                              : ram_out_rdata_i[0 +: DataWidth];
      end
    end
  end

endmodule
